ofmap_collector: RTL and testbench

- Downstream consumer of the systolic TPU system.
- Captures the de-skewed per-output-channel accumulators (nPEx lanes, 24-bit) while the upstream valid flag is high.
- Requantizes each lane to dataSize with an arithmetic shift, optional ReLU and saturation.
- Stores one word per output pixel into an internal ofmap buffer, readable by the host or the next layer through a 1-cycle-latency read port.

---
 rtl/tpu_pkg.sv | 65 ++++++
 rtl/requant_lane.sv | 16 +
 rtl/ofmap_collector.sv | 135 +++++++++++++
 tb/tb_ofmap_collector.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic TPU output path: sizes, the ofmap
// collector state encoding and the per-lane requantizer function.
// Optional feature: OFMAP_COLLECTOR_ROUND_EN selects round-half-away-from-zero
// before the shift; the default is plain arithmetic truncation (floor).
package tpu_pkg;

    localparam int unsigned ACC_SIZE  = 24;
    localparam int unsigned DATA_SIZE = 8;
    localparam int unsigned SHIFT_W   = 5;
    localparam int unsigned MAX_SHIFT = 23;

    localparam int SAT_MAX_I = (1 <<< (DATA_SIZE - 1)) - 1;
    localparam int SAT_MIN_I = -SAT_MAX_I - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } collector_state_t;

    // Shift right (optionally rounded), optional ReLU, saturate to DATA_SIZE.
    function automatic logic [DATA_SIZE-1:0] sat_shift(
        input logic [ACC_SIZE-1:0] acc,
        input logic [SHIFT_W-1:0]  shift,
        input logic                relu
    );
        logic [SHIFT_W-1:0]        sh;
        logic signed [ACC_SIZE:0]  wide;
        logic signed [ACC_SIZE:0]  s;
        logic signed [ACC_SIZE:0]  sat_max;
        logic signed [ACC_SIZE:0]  sat_min;
        logic [DATA_SIZE-1:0]      res;
`ifdef OFMAP_COLLECTOR_ROUND_EN
        logic [ACC_SIZE:0]         half;
`endif
        sh      = (shift > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : shift;
        // One guard bit keeps the rounding add from wrapping.
        wide    = $signed({acc[ACC_SIZE-1], acc});
`ifdef OFMAP_COLLECTOR_ROUND_EN
        if (sh != '0) begin
            half = (ACC_SIZE+1)'(1) << (sh - SHIFT_W'(1));
            if (acc[ACC_SIZE-1]) begin
                half = half - (ACC_SIZE+1)'(1);
            end
            wide = wide + $signed(half);
        end
`endif
        s       = wide >>> sh;
        if (relu && s[ACC_SIZE]) begin
            s = '0;
        end
        sat_max = (ACC_SIZE+1)'(SAT_MAX_I);
        sat_min = (ACC_SIZE+1)'(SAT_MIN_I);
        if (s > sat_max) begin
            res = sat_max[DATA_SIZE-1:0];
        end else if (s < sat_min) begin
            res = sat_min[DATA_SIZE-1:0];
        end else begin
            res = s[DATA_SIZE-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/requant_lane.sv
// Combinational requantizer for one output-channel lane.
// Ports: acc (signed accumulator), shift (right-shift amount), relu (clamp
// negatives), q_c (saturated DATA_SIZE result).
// Rounding behaviour follows OFMAP_COLLECTOR_ROUND_EN through tpu_pkg.
module requant_lane
    import tpu_pkg::*;
(
    input  logic [ACC_SIZE-1:0]  acc,
    input  logic [SHIFT_W-1:0]   shift,
    input  logic                 relu,
    output logic [DATA_SIZE-1:0] q_c
);

    assign q_c = sat_shift(acc, shift, relu);

endmodule

// File: rtl/ofmap_collector.sv
// Ofmap collector: captures de-skewed accumulators while acc_valid is high,
// requantizes every lane and stores one word per pixel in an internal buffer
// with a registered 1-cycle read port.
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   acc_in, acc_valid, acc_last  accumulator lanes and upstream flags
//   ctrl_start                arm/restart a frame
//   cfg_shift, cfg_relu_en    requantization settings (stable over a frame)
//   rd_en, rd_addr, rd_data   buffer read port
//   wr_count                  pixels stored this frame
//   flag_busy, flag_done, flag_overflow  status
// Optional feature: OFMAP_COLLECTOR_ROUND_EN (rounding in the requantizer).
module ofmap_collector
    import tpu_pkg::*;
#(
    parameter int unsigned dataSize      = 8,
    parameter int unsigned numOutChannel = 3,
    parameter int unsigned accSize       = 24,
    parameter int unsigned numRegister   = 256,
    localparam int unsigned numAddrBuffer = $clog2(numRegister)
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic [numOutChannel*accSize-1:0]  acc_in,
    input  logic                              acc_valid,
    input  logic                              acc_last,
    input  logic                              ctrl_start,
    input  logic [4:0]                        cfg_shift,
    input  logic                              cfg_relu_en,
    input  logic                              rd_en,
    input  logic [numAddrBuffer-1:0]          rd_addr,
    output logic [numOutChannel*dataSize-1:0] rd_data,
    output logic [numAddrBuffer:0]            wr_count,
    output logic                              flag_busy,
    output logic                              flag_done,
    output logic                              flag_overflow
);

    localparam int unsigned WORD_W = numOutChannel * dataSize;
    localparam int unsigned ACC_W  = numOutChannel * accSize;
    localparam int unsigned CNT_W  = numAddrBuffer + 1;

    collector_state_t state, state_nx;
    logic             drain_cnt, drain_cnt_nx;
    logic             s1_valid;
    logic [ACC_W-1:0] s1_acc;
    logic [WORD_W-1:0] q_word_c;
    logic [WORD_W-1:0] mem [numRegister];
    logic             full_c;
    logic             wr_en_c;
    logic             ovf_set_c;
    logic             in_collect_c;

    // Next-state logic; ctrl_start overrides every state.
    always_comb begin
        state_nx     = state;
        drain_cnt_nx = 1'b0;
        case (state)
            IDLE:    ;
            COLLECT: if (acc_last) state_nx = DRAIN;
            DRAIN: begin
                if (drain_cnt) begin
                    state_nx = DONE;
                end else begin
                    drain_cnt_nx = 1'b1;
                end
            end
            default: ;
        endcase
        if (ctrl_start) begin
            state_nx     = COLLECT;
            drain_cnt_nx = 1'b0;
        end
    end

    assign in_collect_c = (state == COLLECT);
    assign full_c       = (wr_count == CNT_W'(numRegister));
    // A restart in the same cycle discards the sample sitting in S1.
    assign wr_en_c      = s1_valid && !ctrl_start && !full_c;
    assign ovf_set_c    = s1_valid && !ctrl_start && full_c;

    for (genvar i = 0; i < numOutChannel; i++) begin : g_lane
        requant_lane u_lane (
            .acc   (s1_acc[i*accSize +: accSize]),
            .shift (cfg_shift),
            .relu  (cfg_relu_en),
            .q_c   (q_word_c[i*dataSize +: dataSize])
        );
    end

    // State, pipeline valid, counters, flags and read data.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            drain_cnt     <= 1'b0;
            s1_valid      <= 1'b0;
            wr_count      <= '0;
            rd_data       <= '0;
            flag_busy     <= 1'b0;
            flag_done     <= 1'b0;
            flag_overflow <= 1'b0;
        end else begin
            state     <= state_nx;
            drain_cnt <= drain_cnt_nx;
            s1_valid  <= acc_valid && in_collect_c && !ctrl_start;
            flag_busy <= (state_nx == COLLECT) || (state_nx == DRAIN);
            flag_done <= (state_nx == DONE);
            if (ctrl_start) begin
                wr_count      <= '0;
                flag_overflow <= 1'b0;
            end else begin
                if (wr_en_c) begin
                    wr_count <= wr_count + CNT_W'(1);
                end
                if (ovf_set_c) begin
                    flag_overflow <= 1'b1;
                end
            end
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

    // Datapath storage without reset: S1 sample and buffer (wr_ptr == wr_count).
    always_ff @(posedge clk) begin
        if (acc_valid && in_collect_c) begin
            s1_acc <= acc_in;
        end
        if (wr_en_c) begin
            mem[wr_count[numAddrBuffer-1:0]] <= q_word_c;
        end
    end

endmodule

// File: tb/tb_ofmap_collector.sv
// Self-checking bench for ofmap_collector: reference model of the buffer,
// expected read words queued at issue and compared by an independent monitor.
module tb_ofmap_collector;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int NL    = 3;
    localparam int DW    = 8;
    localparam int AccW  = 24;

    logic                 clk = 1'b0;
    logic                 nrst;
    logic [NL*AccW-1:0]   acc_in;
    logic                 acc_valid;
    logic                 acc_last;
    logic                 ctrl_start;
    logic [4:0]           cfg_shift;
    logic                 cfg_relu_en;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic [NL*DW-1:0]     rd_data;
    logic [AW:0]          wr_count;
    logic                 flag_busy;
    logic                 flag_done;
    logic                 flag_overflow;

    ofmap_collector #(.numRegister(DEPTH)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .acc_in        (acc_in),
        .acc_valid     (acc_valid),
        .acc_last      (acc_last),
        .ctrl_start    (ctrl_start),
        .cfg_shift     (cfg_shift),
        .cfg_relu_en   (cfg_relu_en),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .wr_count      (wr_count),
        .flag_busy     (flag_busy),
        .flag_done     (flag_done),
        .flag_overflow (flag_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [NL*DW-1:0] model_mem [DEPTH];
    int               m_count;
    bit               m_ovf;
    int               cur_shift;
    bit               cur_relu;
    int               pix [NL];
    logic [NL*DW-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requantization written from the arithmetic definition (division based).
    function automatic int ref_q(input int acc, input int sh, input bit relu);
        int s;
        int p;
        int q;
        s = (sh > 23) ? 23 : sh;
        p = 1 << s;
`ifdef OFMAP_COLLECTOR_ROUND_EN
        if (s == 0)        q = acc;
        else if (acc >= 0) q = (acc + p / 2) / p;
        else               q = -((-acc + p / 2) / p);
`else
        if (acc >= 0) q = acc / p;
        else          q = -((-acc + p - 1) / p);
`endif
        if (relu && q < 0) q = 0;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    task automatic model_pix();
        logic [NL*DW-1:0] w;
        for (int i = 0; i < NL; i++) w[i*DW +: DW] = DW'(ref_q(pix[i], cur_shift, cur_relu));
        if (m_count < DEPTH) begin
            model_mem[m_count] = w;
            m_count++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic rand_pix();
        logic [31:0] r;
        for (int i = 0; i < NL; i++) begin
            r = $urandom;
            case ($urandom % 3)
                0:       pix[i] = int'($urandom_range(0, 4000)) - 2000;
                1:       pix[i] = int'({{8{r[23]}}, r[23:0]});
                default: pix[i] = int'($urandom_range(0, 200)) - 100;
            endcase
        end
    endtask

    task automatic drive(input bit v, input bit l);
        acc_valid = v;
        acc_last  = l;
        for (int i = 0; i < NL; i++) acc_in[i*AccW +: AccW] = AccW'(pix[i]);
        @(negedge clk);
        acc_valid = 1'b0;
        acc_last  = 1'b0;
    endtask

    task automatic start(input int sh, input bit relu);
        cur_shift   = sh;
        cur_relu    = relu;
        cfg_shift   = 5'(sh);
        cfg_relu_en = relu;
        ctrl_start  = 1'b1;
        @(negedge clk);
        ctrl_start  = 1'b0;
        m_count     = 0;
        m_ovf       = 1'b0;
    endtask

    // Entered one cycle after the acc_last cycle; k counts cycles since it.
    task automatic wait_done(input int exp_lat);
        int k;
        k = 1;
        while (flag_done !== 1'b1 && k < 12) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 32'(flag_done), 32'd1);
        if (exp_lat >= 0) check("done_latency", 32'(k), 32'(exp_lat));
    endtask

    task automatic check_status(input string tag);
        check({tag, "_wr_count"}, 32'(wr_count), 32'(m_count));
        check({tag, "_overflow"}, 32'(flag_overflow), 32'(m_ovf));
        check({tag, "_busy"}, 32'(flag_busy), 32'd0);
    endtask

    task automatic read(input int a, input logic [NL*DW-1:0] e);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        exp_q.push_back(e);
        @(negedge clk);
        rd_en   = 1'b0;
    endtask

    // Monitor: every accepted read is compared half a cycle after its edge.
    initial begin
        logic [NL*DW-1:0] e;
        forever begin
            @(posedge clk);
            if (nrst === 1'b1 && rd_en === 1'b1) begin
                @(negedge clk);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL rd_unexpected: got %0h with no expected entry", rd_data);
                end else begin
                    n_checks--;
                    e = exp_q.pop_front();
                    check("rd_data", 32'(rd_data), 32'(e));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NL*DW-1:0] old2;
        int n;
        bit last_sep;

        nrst = 1'b0; acc_in = '0; acc_valid = 1'b0; acc_last = 1'b0;
        ctrl_start = 1'b0; cfg_shift = '0; cfg_relu_en = 1'b0;
        rd_en = 1'b0; rd_addr = '0;
        for (int i = 0; i < NL; i++) pix[i] = 0;
        m_count = 0; m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_busy", 32'(flag_busy), 32'd0);
        check("rst_done", 32'(flag_done), 32'd0);
        check("rst_overflow", 32'(flag_overflow), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        nrst = 1'b1;
        @(negedge clk);

        // Valid pixels in IDLE are ignored
        rand_pix(); drive(1, 0); drive(1, 0); drive(1, 1);
        repeat (3) @(negedge clk);
        check("idle_wr_count", 32'(wr_count), 32'd0);
        check("idle_busy", 32'(flag_busy), 32'd0);

        // Basic frame
        start(0, 0);
        check("start_busy", 32'(flag_busy), 32'd1);
        foreach (pix[i]) pix[i] = 0;
        rand_pix(); pix[0] = 100;  model_pix(); drive(1, 0);
        rand_pix(); pix[0] = -100; model_pix(); drive(1, 0);
        rand_pix(); pix[0] = 300;  model_pix(); drive(1, 0);
        rand_pix(); pix[0] = 5;    model_pix(); drive(1, 1);
        wait_done(3);
        check("basic_wr_count", 32'(wr_count), 32'd4);
        check_status("basic");
        for (int a = 0; a < 4; a++) read(a, model_mem[a]);

        // Pixels in DONE are ignored
        rand_pix(); drive(1, 0); drive(1, 1); drive(1, 0);
        repeat (3) @(negedge clk);
        check("done_ign_wr_count", 32'(wr_count), 32'(m_count));
        check("done_ign_done", 32'(flag_done), 32'd1);

        // ReLU and shift
        start(3, 1);
        rand_pix(); pix[0] = -64;  model_pix(); drive(1, 0);
        rand_pix(); pix[0] = 1000; model_pix(); drive(1, 0);
        rand_pix(); pix[0] = 1004; model_pix(); drive(1, 1);
        wait_done(3);
        check_status("relu");
        for (int a = 0; a < 3; a++) read(a, model_mem[a]);

        // Read of addr 2 in the same cycle it is rewritten returns the old word
        start(0, 0);
        old2 = model_mem[2];
        for (int p = 0; p < 3; p++) begin
            rand_pix(); model_pix(); drive(1, 0);
        end
        rd_en = 1'b1; rd_addr = AW'(2); exp_q.push_back(old2);
        drive(0, 1);
        rd_en = 1'b0;
        wait_done(-1);
        check_status("raw");
        read(2, model_mem[2]);

        // Restart mid-frame
        start(0, 0);
        rand_pix(); model_pix(); drive(1, 0);
        rand_pix(); model_pix(); drive(1, 0);
        rand_pix(); drive(1, 0);
        ctrl_start = 1'b1; drive(0, 0); ctrl_start = 1'b0;
        m_count = 0; m_ovf = 1'b0;
        check("restart_wr_count", 32'(wr_count), 32'd0);
        check("restart_done", 32'(flag_done), 32'd0);
        check("restart_busy", 32'(flag_busy), 32'd1);
        @(negedge clk);
        check("restart_flush", 32'(wr_count), 32'd0);
        foreach (pix[i]) pix[i] = 7;
        model_pix(); drive(1, 1);
        wait_done(3);
        check_status("restart");
        read(0, model_mem[0]);

        // Randomized frames, including overflow and shift values above 23
        for (int f = 0; f < 25; f++) begin
            start(int'($urandom_range(0, 31)), bit'($urandom % 2));
            n = (f == 0) ? 20 : int'($urandom_range(1, 20));
            last_sep = bit'($urandom % 2);
            for (int p = 0; p < n; p++) begin
                if ($urandom % 4 == 0) drive(0, 0);
                rand_pix(); model_pix();
                drive(1, (p == n - 1) && !last_sep);
            end
            if (last_sep) drive(0, 1);
            wait_done(3);
            check_status("rand");
            for (int a = 0; a < m_count; a++) read(a, model_mem[a]);
        end

        // Reset during DRAIN
        start(2, 0);
        rand_pix(); model_pix(); drive(1, 0);
        rand_pix(); model_pix(); drive(1, 1);
        #2 nrst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(flag_busy), 32'd0);
        check("mid_rst_done", 32'(flag_done), 32'd0);
        check("mid_rst_overflow", 32'(flag_overflow), 32'd0);
        check("mid_rst_wr_count", 32'(wr_count), 32'd0);
        check("mid_rst_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", 32'(flag_busy), 32'd0);
        check("post_rst_done", 32'(flag_done), 32'd0);
        check("post_rst_wr_count", 32'(wr_count), 32'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
